// File: rtl/mul_div_unit_pkg.sv
// Shared opcode and state definitions for the HI/LO multiply/divide unit.
// Funct codes follow the MIPS SPECIAL encoding.
package mul_div_unit_pkg;

  localparam logic [5:0] SPECIAL_MFHI  = 6'h10;
  localparam logic [5:0] SPECIAL_MTHI  = 6'h11;
  localparam logic [5:0] SPECIAL_MFLO  = 6'h12;
  localparam logic [5:0] SPECIAL_MTLO  = 6'h13;
  localparam logic [5:0] SPECIAL_MULT  = 6'h18;
  localparam logic [5:0] SPECIAL_MULTU = 6'h19;
  localparam logic [5:0] SPECIAL_DIV   = 6'h1a;
  localparam logic [5:0] SPECIAL_DIVU  = 6'h1b;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } md_state_e;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } md_op_e;

  // MFHI/MFLO read the outputs directly, so they are not operations here.
  function automatic md_op_e decode_op(input logic [5:0] funct);
    case (funct)
      SPECIAL_MULT:  return OP_MULT;
      SPECIAL_MULTU: return OP_MULTU;
      SPECIAL_DIV:   return OP_DIV;
      SPECIAL_DIVU:  return OP_DIVU;
      SPECIAL_MTHI:  return OP_MTHI;
      SPECIAL_MTLO:  return OP_MTLO;
      default:       return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO; one FSM drives a shared
// 2*WIDTH shift register and a single adder used by both shift-add and restoring division.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             w_clock,
  input  logic             w_reset_n,
  input  logic             w_start,
  input  logic [5:0]       w_op_code_6,
  input  logic [WIDTH-1:0] w_input1_x,
  input  logic [WIDTH-1:0] w_input2_x,
  output logic             w_busy,
  output logic             w_done,
  output logic             w_div_by_zero,
  output logic [WIDTH-1:0] w_hi_x,
  output logic [WIDTH-1:0] w_lo_x
);

  localparam int CNT_W = $clog2(WIDTH);

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  md_state_e          state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic               dbz_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   op_q;
  logic               is_div_q;
  logic               neg_res_q;
  logic               neg_rem_q;

  md_op_e             op;
  logic               accept;
  logic               op_signed;
  logic               op_is_div;
  logic               op_div0;
  logic [WIDTH-1:0]   rs_mag;
  logic [WIDTH-1:0]   rt_mag;

  assign op        = decode_op(w_op_code_6);
  assign accept    = w_start && (state_q == IDLE || state_q == DONE) && (op != OP_NONE);
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign op_is_div = (op == OP_DIV) || (op == OP_DIVU);
  assign op_div0   = op_is_div && (w_input2_x == '0);
  assign rs_mag    = magnitude(w_input1_x, op_signed);
  assign rt_mag    = magnitude(w_input2_x, op_signed);

  // Shared adder: multiply adds the multiplicand into the upper half, divide
  // subtracts the divisor from the shifted partial remainder (carry-in = 1).
  logic [WIDTH+1:0]   add_a;
  logic [WIDTH+1:0]   add_b;
  logic               add_cin;
  logic [WIDTH+1:0]   add_sum;
  logic [2*WIDTH-1:0] acc_nxt;

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (is_div_q) begin
      add_a   = {1'b0, acc_q[2*WIDTH-1:WIDTH-1]};
      add_b   = ~{2'b00, op_q};
      add_cin = 1'b1;
    end else begin
      add_a   = {2'b00, acc_q[2*WIDTH-1:WIDTH]};
      add_b   = acc_q[0] ? {2'b00, op_q} : '0;
    end
  end

  assign add_sum = add_a + add_b + {{(WIDTH+1){1'b0}}, add_cin};

  always_comb begin
    acc_nxt = acc_q;
    if (is_div_q) begin
      if (!add_sum[WIDTH+1])
        acc_nxt = {add_sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else
        acc_nxt = {acc_q[2*WIDTH-2:0], 1'b0};
    end else begin
      acc_nxt = {add_sum[WIDTH:0], acc_q[WIDTH-1:1]};
    end
  end

  // Sign fix-up applied on the FIX edge; a zero divisor preloads acc with {rs, ones}.
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;
  logic [2*WIDTH-1:0] product;

  assign product = cond_neg_2w(acc_q, neg_res_q);

  always_comb begin
    fix_hi = product[2*WIDTH-1:WIDTH];
    fix_lo = product[WIDTH-1:0];
    if (dbz_q) begin
      fix_hi = acc_q[2*WIDTH-1:WIDTH];
      fix_lo = acc_q[WIDTH-1:0];
    end else if (is_div_q) begin
      fix_hi = cond_neg_w(acc_q[2*WIDTH-1:WIDTH], neg_rem_q);
      fix_lo = cond_neg_w(acc_q[WIDTH-1:0], neg_res_q);
    end
  end

  // Control and architectural state
  always_ff @(posedge w_clock or negedge w_reset_n) begin
    if (!w_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            dbz_q <= op_div0;
            cnt_q <= CNT_W'(WIDTH - 1);
            if (op == OP_MTHI) begin
              hi_q    <= w_input1_x;
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (op == OP_MTLO) begin
              lo_q    <= w_input1_x;
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (op_div0) begin
              state_q <= FIX;
              busy_q  <= 1'b1;
            end else begin
              state_q <= CALC;
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          if (cnt_q == '0)
            state_q <= FIX;
          else
            cnt_q <= cnt_q - 1'b1;
        end
        FIX: begin
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Datapath registers: loaded on accept, iterated in CALC
  always_ff @(posedge w_clock) begin
    if (accept) begin
      is_div_q  <= op_is_div;
      neg_res_q <= op_signed && (w_input1_x[WIDTH-1] ^ w_input2_x[WIDTH-1]);
      neg_rem_q <= op_signed && w_input1_x[WIDTH-1];
      if (op_is_div) begin
        op_q  <= rt_mag;
        acc_q <= op_div0 ? {w_input1_x, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, rs_mag};
      end else begin
        op_q  <= rs_mag;
        acc_q <= {{WIDTH{1'b0}}, rt_mag};
      end
    end else if (state_q == CALC) begin
      acc_q <= acc_nxt;
    end
  end

  assign w_busy        = busy_q;
  assign w_done        = done_q;
  assign w_div_by_zero = dbz_q;
  assign w_hi_x        = hi_q;
  assign w_lo_x        = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and random checks of mul_div_unit against an arithmetic model of HI/LO.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  op_code = 6'h0;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mul_div_unit #(.WIDTH(32)) dut (
    .w_clock(clk), .w_reset_n(rst_n), .w_start(start), .w_op_code_6(op_code),
    .w_input1_x(in1), .w_input2_x(in2), .w_busy(busy), .w_done(done),
    .w_div_by_zero(dbz), .w_hi_x(hi), .w_lo_x(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Architectural result from plain arithmetic; also returns expected timing.
  task automatic model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] e_hi, output logic [31:0] e_lo, output logic e_dbz,
                       output int e_lat, output int e_busy);
    longint sa, sb, q, r;
    logic [63:0] p;
    e_hi = m_hi; e_lo = m_lo; e_dbz = 1'b0; e_lat = 34; e_busy = 33;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      SPECIAL_MTHI: begin e_hi = a; e_lat = 1; e_busy = 0; end
      SPECIAL_MTLO: begin e_lo = a; e_lat = 1; e_busy = 0; end
      SPECIAL_MULTU: begin p = {32'h0, a} * {32'h0, b}; {e_hi, e_lo} = p; end
      SPECIAL_MULT: begin p = 64'(sa * sb); {e_hi, e_lo} = p; end
      SPECIAL_DIV, SPECIAL_DIVU: begin
        if (b == 32'h0) begin
          e_lo = 32'hFFFF_FFFF; e_hi = a; e_dbz = 1'b1; e_lat = 2; e_busy = 1;
        end else if (op == SPECIAL_DIVU) begin
          e_lo = a / b; e_hi = a % b;
        end else begin
          q = sa / sb; r = sa % sb;
          e_lo = q[31:0]; e_hi = r[31:0];
        end
      end
      default: ;
    endcase
    m_hi = e_hi; m_lo = e_lo;
  endtask

  task automatic do_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int poke, input string tag);
    logic [31:0] e_hi, e_lo, old_hi, old_lo;
    logic e_dbz;
    int e_lat, e_busy, cyc, busy_cnt, hold_bad;
    model(op, a, b, e_hi, e_lo, e_dbz, e_lat, e_busy);
    old_hi = hi; old_lo = lo;
    op_code = op; in1 = a; in2 = b; start = 1'b1;
    step();
    start = 1'b0; cyc = 1; busy_cnt = 0; hold_bad = 0;
    while (!done && cyc < 100) begin
      if (busy) busy_cnt++;
      if (busy && (hi !== old_hi || lo !== old_lo)) hold_bad++;
      if (cyc == poke) begin
        start = 1'b1; op_code = SPECIAL_MULTU; in1 = $urandom; in2 = $urandom;
      end else begin
        start = 1'b0;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(cyc), 64'(e_lat));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(e_busy));
    check({tag, "_hold"}, 64'(hold_bad), 64'd0);
    check({tag, "_hi"}, 64'(hi), 64'(e_hi));
    check({tag, "_lo"}, 64'(lo), 64'(e_lo));
    check({tag, "_dbz"}, 64'(dbz), 64'(e_dbz));
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    step();
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int bad;
    logic [5:0] ops [4];
    ops[0] = SPECIAL_MULT; ops[1] = SPECIAL_MULTU; ops[2] = SPECIAL_DIV; ops[3] = SPECIAL_DIVU;

    // Reset state
    #1;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dbz", 64'(dbz), 64'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Directed vectors
    do_op(SPECIAL_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, "multu_max");
    check("multu_max_hi_const", 64'(hi), 64'hFFFF_FFFE);
    check("multu_max_lo_const", 64'(lo), 64'h0000_0001);
    do_op(SPECIAL_MULT, 32'hFFFF_FFFD, 32'd7, 5, "mult_m3x7_poke");
    check("mult_m3x7_lo_const", 64'(lo), 64'hFFFF_FFEB);
    do_op(SPECIAL_DIV, 32'hFFFF_FFF9, 32'd2, -1, "div_m7_2");
    check("div_m7_2_lo_const", 64'(lo), 64'hFFFF_FFFD);
    do_op(SPECIAL_DIVU, 32'd100, 32'd7, -1, "divu_100_7");
    check("divu_100_7_lo_const", 64'(lo), 64'd14);
    do_op(SPECIAL_DIV, 32'd5, 32'd0, -1, "div_5_0");
    check("div_5_0_dbz_sticky", 64'(dbz), 64'd1);
    do_op(SPECIAL_MULTU, 32'd3, 32'd4, -1, "multu_clear_dbz");
    do_op(SPECIAL_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, "div_minint");
    check("div_minint_lo_const", 64'(lo), 64'h8000_0000);
    do_op(SPECIAL_DIV, 32'hFFFF_FFF9, 32'd0, -1, "div_neg_0");
    do_op(SPECIAL_MULT, 32'h8000_0000, 32'h8000_0000, -1, "mult_minint_sq");

    // MTHI then MTLO back-to-back
    op_code = SPECIAL_MTHI; in1 = 32'h1234; start = 1'b1;
    step();
    check("mthi_done", 64'(done), 64'd1);
    check("mthi_busy", 64'(busy), 64'd0);
    check("mthi_hi", 64'(hi), 64'h1234);
    op_code = SPECIAL_MTLO; in1 = 32'h5678;
    step();
    start = 1'b0;
    check("mtlo_done", 64'(done), 64'd1);
    check("mtlo_busy", 64'(busy), 64'd0);
    check("mtlo_lo", 64'(lo), 64'h5678);
    check("mtlo_hi_kept", 64'(hi), 64'h1234);
    step();
    check("mt_done_clear", 64'(done), 64'd0);
    m_hi = 32'h1234; m_lo = 32'h5678;

    // Unknown op never leaves idle
    op_code = SPECIAL_MFHI; in1 = 32'hDEAD; start = 1'b1; bad = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (busy || done) bad++;
    end
    start = 1'b0;
    check("unknown_op_quiet", 64'(bad), 64'd0);
    check("unknown_op_hi", 64'(hi), 64'(m_hi));

    // Reset in the middle of CALC
    op_code = SPECIAL_MULT; in1 = 32'd123; in2 = 32'd456; start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    check("midreset_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midreset_hi", 64'(hi), 64'd0);
    check("midreset_lo", 64'(lo), 64'd0);
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_done", 64'(done), 64'd0);
    step();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done || busy) bad++;
    end
    check("midreset_no_done", 64'(bad), 64'd0);
    m_hi = '0; m_lo = '0;
    do_op(SPECIAL_MULT, 32'hFFFF_FFFD, 32'd7, -1, "after_reset_mult");

    // Random operations
    for (int i = 0; i < 20; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
      do_op(ops[$urandom_range(0, 3)], a, b, -1, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
